// File: rtl/trace_stream_serialiser_pkg.sv
// Shared trace datatypes: the completed trace record, the serialiser FSM
// states and the beat-count helper.
package ryuki_datatypes;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [2:0]  flags;
  } trace_output;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } trace_ser_state_e;

  function automatic int unsigned beat_count(input int unsigned rec_w,
                                             input int unsigned tdata_w);
    return (rec_w + tdata_w - 1) / tdata_w;
  endfunction

endpackage

// File: rtl/trace_record_fifo.sv
// Record FIFO: registered write, combinational head, full/empty flags and
// an occupancy count one bit wider than the pointers.
module trace_record_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (occupancy == (AW+1)'(DEPTH));
  assign empty   = (occupancy == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/trace_stream_serialiser.sv
// Buffers trace records and serialises them LSB-first into valid/ready beats.
// Optional feature macro TRACE_STREAM_TIMESTAMP_EN prepends a cycle-count beat.
module trace_stream_serialiser
  import ryuki_datatypes::*;
#(
  parameter int TDATA_WIDTH    = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trace_valid_i,
  input  trace_output               trace_data_i,
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  output logic [TDATA_WIDTH-1:0]    m_tdata_o,
  output logic                      m_tlast_o,
  output logic                      fifo_full_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_count_o
);

  localparam int REC_W = $bits(trace_output);
  localparam int BEATS = beat_count(REC_W, TDATA_WIDTH);
  localparam int PAD_W = BEATS * TDATA_WIDTH;
`ifdef TRACE_STREAM_TIMESTAMP_EN
  localparam int TOT_BEATS = BEATS + 1;
  localparam int ENTRY_W   = REC_W + TDATA_WIDTH;
`else
  localparam int TOT_BEATS = BEATS;
  localparam int ENTRY_W   = REC_W;
`endif
  localparam int SHIFT_W = TOT_BEATS * TDATA_WIDTH;
  localparam int IDX_W   = $clog2(TOT_BEATS + 1);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOT_BEATS - 1);

  trace_ser_state_e   state;
  trace_ser_state_e   next_state;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] head;
  logic [SHIFT_W-1:0] entry_padded;
  logic [SHIFT_W-1:0] shift_q;
  logic [IDX_W-1:0]   beat_idx;
  logic [CNT_W-1:0]   occupancy;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               handshake;
  logic               last_beat;

`ifdef TRACE_STREAM_TIMESTAMP_EN
  logic [TDATA_WIDTH-1:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TDATA_WIDTH'(1);
    end
  end

  // Timestamp occupies the low word so it leaves as beat 0.
  assign entry_in     = {trace_data_i, ts_q};
  assign entry_padded = {PAD_W'(head[ENTRY_W-1:TDATA_WIDTH]), head[TDATA_WIDTH-1:0]};
`else
  assign entry_in     = trace_data_i;
  assign entry_padded = PAD_W'(head);
`endif

  assign push        = trace_valid_i && !full;
  assign handshake   = m_tvalid_o && m_tready_i;
  assign last_beat   = (beat_idx == LAST_IDX);
  assign m_tlast_o   = m_tvalid_o && last_beat;
  assign fifo_full_o = (occupancy == CNT_W'(FIFO_DEPTH));

  trace_record_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (entry_in),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: next_state = SEND;
      SEND: begin
        if (handshake && last_beat) begin
          if (!empty) begin
            pop        = 1'b1;
            next_state = LOAD;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Beats leave from the bottom of the shift register; output beat is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      beat_idx   <= '0;
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
    end else begin
      if (pop) begin
        shift_q  <= entry_padded;
        beat_idx <= '0;
      end
      if (state == LOAD) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= shift_q[TDATA_WIDTH-1:0];
        shift_q    <= shift_q >> TDATA_WIDTH;
      end else if (state == SEND && handshake) begin
        if (!last_beat) begin
          m_tdata_o <= shift_q[TDATA_WIDTH-1:0];
          shift_q   <= shift_q >> TDATA_WIDTH;
          beat_idx  <= beat_idx + IDX_W'(1);
        end else begin
          m_tvalid_o <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_o <= '0;
    end else if (trace_valid_i && full && (drop_count_o != '1)) begin
      drop_count_o <= drop_count_o + DROP_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_trace_stream_serialiser.sv
// Directed bench for trace_stream_serialiser with a 72-bit record, 32-bit beats
// and a 4-deep FIFO.
module tb_trace_stream_serialiser;
  import ryuki_datatypes::*;

  localparam int TDW   = 32;
  localparam int DEPTH = 4;
  localparam int DCW   = 16;
  localparam int BEATS = 3;

  typedef struct {
    logic [71:0]          rec;
    logic [2:0][TDW-1:0]  beats;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            trace_valid_i;
  trace_output     trace_data_i;
  logic            m_tvalid_o;
  logic            m_tready_i;
  logic [TDW-1:0]  m_tdata_o;
  logic            m_tlast_o;
  logic            fifo_full_o;
  logic [DCW-1:0]  drop_count_o;

  int tests_run = 0;
  int tests_failed = 0;

  vec_t               vecs[4];
  logic [71:0]        recs[6];
  logic [2:0][TDW-1:0] exp_beats;

  trace_stream_serialiser #(
    .TDATA_WIDTH    (TDW),
    .FIFO_DEPTH     (DEPTH),
    .DROP_CNT_WIDTH (DCW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trace_valid_i (trace_valid_i),
    .trace_data_i  (trace_data_i),
    .m_tvalid_o    (m_tvalid_o),
    .m_tready_i    (m_tready_i),
    .m_tdata_o     (m_tdata_o),
    .m_tlast_o     (m_tlast_o),
    .fifo_full_o   (fifo_full_o),
    .drop_count_o  (drop_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0][TDW-1:0] beats_of(input logic [71:0] r);
    logic [2:0][TDW-1:0] b;
    b[0] = r[31:0];
    b[1] = r[63:32];
    b[2] = {24'h0, r[71:64]};
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [71:0] r);
    trace_valid_i = 1'b1;
    trace_data_i  = trace_output'(r);
    tick();
    trace_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int waited = 0;
    while (!m_tvalid_o && waited < 20) begin
      tick();
      waited++;
    end
    check_output($sformatf("%s_valid", tag), 64'(m_tvalid_o), 64'd1);
  endtask

  // Expects ready held high: one beat per cycle, tlast only on the final one.
  task automatic receive_packet(input logic [2:0][TDW-1:0] exp, input string tag);
    wait_valid(tag);
    for (int k = 0; k < BEATS; k++) begin
      check_output($sformatf("%s_b%0d_valid", tag, k), 64'(m_tvalid_o), 64'd1);
      check_output($sformatf("%s_b%0d_data", tag, k), 64'(m_tdata_o), 64'(exp[k]));
      check_output($sformatf("%s_b%0d_last", tag, k), 64'(m_tlast_o),
                   (k == BEATS - 1) ? 64'd1 : 64'd0);
      tick();
    end
  endtask

  initial begin
    vecs[0].rec   = 72'hA5_1122_3344_5566_7788;
    vecs[0].beats = {32'h0000_00A5, 32'h1122_3344, 32'h5566_7788};
    vecs[1].rec   = 72'hFF_FFFF_FFFF_FFFF_FFFF;
    vecs[1].beats = {32'h0000_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[2].rec   = 72'h00_0000_0000_0000_0000;
    vecs[2].beats = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[3].rec   = 72'h3C_DEAD_BEEF_CAFE_F00D;
    vecs[3].beats = {32'h0000_003C, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    for (int i = 0; i < 6; i++) begin
      recs[i] = {8'(8'hC0 + i), 32'(32'h1000_0001 * (i + 1)), 32'(32'hA000_0000 + i)};
    end

    rst           = 1'b1;
    trace_valid_i = 1'b0;
    trace_data_i  = '0;
    m_tready_i    = 1'b0;
    #12;
    check_output("rst_tvalid", 64'(m_tvalid_o), 64'd0);
    check_output("rst_tdata", 64'(m_tdata_o), 64'd0);
    check_output("rst_tlast", 64'(m_tlast_o), 64'd0);
    check_output("rst_full", 64'(fifo_full_o), 64'd0);
    check_output("rst_drop", 64'(drop_count_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Single records: valid rises three cycles after the push.
    m_tready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i].rec);
      check_output($sformatf("v%0d_lat1", i), 64'(m_tvalid_o), 64'd0);
      tick();
      check_output($sformatf("v%0d_lat2", i), 64'(m_tvalid_o), 64'd0);
      tick();
      check_output($sformatf("v%0d_lat3", i), 64'(m_tvalid_o), 64'd1);
      receive_packet(vecs[i].beats, $sformatf("v%0d", i));
      check_output($sformatf("v%0d_end", i), 64'(m_tvalid_o), 64'd0);
    end

    // Back-to-back records with one idle cycle between packets.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(recs[i]);
    end
    for (int p = 0; p < 3; p++) begin
      if (p > 0) begin
        check_output($sformatf("b2b%0d_bubble", p), 64'(m_tvalid_o), 64'd0);
        tick();
        check_output($sformatf("b2b%0d_resume", p), 64'(m_tvalid_o), 64'd1);
      end
      receive_packet(beats_of(recs[p]), $sformatf("b2b%0d", p));
    end
    check_output("b2b_end", 64'(m_tvalid_o), 64'd0);
    check_output("b2b_drop", 64'(drop_count_o), 64'd0);

    // Sink stalled: fifth record fills the FIFO, sixth is dropped.
    m_tready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(recs[i]);
      if (i == 3) check_output("stall_full4", 64'(fifo_full_o), 64'd0);
      if (i == 4) begin
        check_output("stall_full5", 64'(fifo_full_o), 64'd1);
        check_output("stall_drop5", 64'(drop_count_o), 64'd0);
      end
      if (i == 5) begin
        check_output("stall_full6", 64'(fifo_full_o), 64'd1);
        check_output("stall_drop6", 64'(drop_count_o), 64'd1);
      end
    end
    exp_beats = beats_of(recs[0]);
    check_output("stall_hold_valid", 64'(m_tvalid_o), 64'd1);
    check_output("stall_hold_data", 64'(m_tdata_o), 64'(exp_beats[0]));
    m_tready_i = 1'b1;
    for (int p = 0; p < 5; p++) begin
      receive_packet(beats_of(recs[p]), $sformatf("drain%0d", p));
    end
    check_output("drain_end", 64'(m_tvalid_o), 64'd0);
    check_output("drain_full", 64'(fifo_full_o), 64'd0);
    check_output("drain_drop", 64'(drop_count_o), 64'd1);

    // Ready toggling mid-packet: beats hold while stalled, none skipped.
    m_tready_i = 1'b0;
    apply_stimulus(vecs[3].rec);
    wait_valid("tog");
    check_output("tog_b0", 64'(m_tdata_o), 64'(vecs[3].beats[0]));
    tick();
    check_output("tog_b0_hold", 64'(m_tdata_o), 64'(vecs[3].beats[0]));
    check_output("tog_b0_last", 64'(m_tlast_o), 64'd0);
    m_tready_i = 1'b1;
    tick();
    check_output("tog_b1", 64'(m_tdata_o), 64'(vecs[3].beats[1]));
    m_tready_i = 1'b0;
    tick();
    check_output("tog_b1_hold", 64'(m_tdata_o), 64'(vecs[3].beats[1]));
    check_output("tog_b1_last", 64'(m_tlast_o), 64'd0);
    m_tready_i = 1'b1;
    tick();
    check_output("tog_b2", 64'(m_tdata_o), 64'(vecs[3].beats[2]));
    check_output("tog_b2_last", 64'(m_tlast_o), 64'd1);
    m_tready_i = 1'b0;
    tick();
    tick();
    check_output("tog_b2_hold", 64'(m_tdata_o), 64'(vecs[3].beats[2]));
    check_output("tog_b2_hold_last", 64'(m_tlast_o), 64'd1);
    check_output("tog_b2_hold_valid", 64'(m_tvalid_o), 64'd1);
    m_tready_i = 1'b1;
    tick();
    check_output("tog_end", 64'(m_tvalid_o), 64'd0);

    // Reset during beat 1 discards the partial record immediately.
    apply_stimulus(vecs[1].rec);
    wait_valid("rstmid");
    tick();
    check_output("rstmid_b1", 64'(m_tdata_o), 64'(vecs[1].beats[1]));
    #2;
    rst = 1'b1;
    #1;
    check_output("rstmid_tvalid", 64'(m_tvalid_o), 64'd0);
    check_output("rstmid_tdata", 64'(m_tdata_o), 64'd0);
    check_output("rstmid_tlast", 64'(m_tlast_o), 64'd0);
    check_output("rstmid_drop", 64'(drop_count_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_output("rstmid_quiet", 64'(m_tvalid_o), 64'd0);
    apply_stimulus(vecs[0].rec);
    receive_packet(vecs[0].beats, "post_rst");
    check_output("post_rst_end", 64'(m_tvalid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
